// File: rtl/rs232_pkg.sv
// Shared definitions for the RS232 transmit-side arbiter.
//   txState_t     : arbiter FSM states (IDLE, START, WAIT_HI, WAIT_LO)
//   RS232_BYTE_W  : transmitted byte width
//   DEF_START_TO  : default cycles to wait for the transmitter busy to rise
package rs232_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } txState_t;

  localparam int RS232_BYTE_W = 8;
  localparam int DEF_START_TO = 4;

endpackage

// File: rtl/rs232_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority picker.
//   N        : number of requesters
//   req      : request vector
//   last     : index of the previous winner; search starts at last+1 mod N
//   grantIdx : index of the selected requester (0 when none)
//   valid    : a requester was selected
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] grantIdx,
  output logic          valid
);

  logic [IW-1:0] idx;

  // Walk offsets from N down to 1 so the smallest offset from last
  // (the highest-priority candidate) is written last and wins.
  always_comb begin
    grantIdx = '0;
    valid    = 1'b0;
    idx      = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IW'((int'(last) + N - int'(i)) % N);
      if (req[idx]) begin
        grantIdx = idx;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs232_tx_arbiter.sv
// rs232_tx_arbiter: round-robin arbiter sharing one RS232 byte transmitter.
// Optional echo source enabled by macro RS232_TX_ARBITER_ECHO_EN.
// Ports:
//   iCLK, iRST_N (async, active-low)
//   iREQ/iREQ_DATA : per-requester request level and byte (k at [8k+7:8k])
//   oACK           : one-cycle commit pulse per requester
//   oTX_DATA/oTX_START/iTX_BUSY : transmitter handshake
//   iRX_READY/iRX_DATA : received byte strobe (echo only)
//   oGRANT         : current/last grant index, N_REQ means echo
//   oBUSY          : state is not IDLE
//   oECHO_OVF      : sticky echo-byte dropped flag
module rs232_tx_arbiter
  import rs232_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int START_TO = DEF_START_TO
) (
  input  logic                         iCLK,
  input  logic                         iRST_N,
  input  logic [N_REQ-1:0]             iREQ,
  input  logic [RS232_BYTE_W*N_REQ-1:0] iREQ_DATA,
  output logic [N_REQ-1:0]             oACK,
  output logic [RS232_BYTE_W-1:0]      oTX_DATA,
  output logic                         oTX_START,
  input  logic                         iTX_BUSY,
  input  logic                         iRX_READY,
  input  logic [RS232_BYTE_W-1:0]      iRX_DATA,
  output logic [$clog2(N_REQ+1)-1:0]   oGRANT,
  output logic                         oBUSY,
  output logic                         oECHO_OVF
);

  localparam int LW = $clog2(N_REQ);
  localparam int GW = $clog2(N_REQ+1);

  txState_t state, nextState;

  logic [LW-1:0]           last;
  logic [LW-1:0]           pickIdx;
  logic                    pickValid;
  logic                    grantReq;
  logic                    grantEcho;
  logic [7:0]              toCnt;
  logic                    echoValid;
  logic [RS232_BYTE_W-1:0] echoData;

  rr_pick #(.N(N_REQ), .IW(LW)) uPick (
    .req      (iREQ),
    .last     (last),
    .grantIdx (pickIdx),
    .valid    (pickValid)
  );

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) state <= IDLE;
    else         state <= nextState;
  end

  // Echo is considered only when no requester is pending.
  always_comb begin
    nextState = state;
    grantReq  = 1'b0;
    grantEcho = 1'b0;
    case (state)
      IDLE: begin
        if (!iTX_BUSY) begin
          if (pickValid) begin
            grantReq  = 1'b1;
            nextState = START;
          end else if (echoValid) begin
            grantEcho = 1'b1;
            nextState = START;
          end
        end
      end
      START:   nextState = WAIT_HI;
      WAIT_HI: if (iTX_BUSY || toCnt == 8'(START_TO-1)) nextState = WAIT_LO;
      WAIT_LO: if (!iTX_BUSY) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Start pulse and ack are registered on the IDLE->START transition so they
  // are high exactly during the START cycle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      last      <= LW'(N_REQ-1);
      oTX_DATA  <= '0;
      oTX_START <= 1'b0;
      oACK      <= '0;
      oGRANT    <= '0;
      oBUSY     <= 1'b0;
      toCnt     <= '0;
    end else begin
      oTX_START <= grantReq | grantEcho;
      oACK      <= '0;
      oBUSY     <= (nextState != IDLE);
      toCnt     <= (state == WAIT_HI) ? toCnt + 8'd1 : '0;
      if (grantReq) begin
        oACK[pickIdx] <= 1'b1;
        oTX_DATA      <= iREQ_DATA[pickIdx*RS232_BYTE_W +: RS232_BYTE_W];
        oGRANT        <= GW'(pickIdx);
        last          <= pickIdx;
      end else if (grantEcho) begin
        oTX_DATA <= echoData;
        oGRANT   <= GW'(N_REQ);
      end
    end
  end

`ifdef RS232_TX_ARBITER_ECHO_EN
  logic echoClr;

  assign echoClr = (state == START) && (oGRANT == GW'(N_REQ));

  // A byte arriving in the same cycle the buffer is serviced replaces it
  // rather than counting as an overflow.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      echoValid <= 1'b0;
      echoData  <= '0;
      oECHO_OVF <= 1'b0;
    end else if (iRX_READY) begin
      if (echoValid && !echoClr) begin
        oECHO_OVF <= 1'b1;
      end else begin
        echoData  <= iRX_DATA;
        echoValid <= 1'b1;
      end
    end else if (echoClr) begin
      echoValid <= 1'b0;
    end
  end
`else
  logic unusedRx;

  assign echoValid = 1'b0;
  assign echoData  = '0;
  assign oECHO_OVF = 1'b0;
  assign unusedRx  = ^{iRX_READY, iRX_DATA};
`endif

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
module tb_rs232_tx_arbiter;

  logic        iCLK = 1'b0;
  logic        iRST_N = 1'b0;
  logic [3:0]  iREQ = '0;
  logic [31:0] iREQ_DATA = '0;
  logic [3:0]  oACK;
  logic [7:0]  oTX_DATA;
  logic        oTX_START;
  logic        iTX_BUSY;
  logic        iRX_READY = 1'b0;
  logic [7:0]  iRX_DATA = '0;
  logic [2:0]  oGRANT;
  logic        oBUSY;
  logic        oECHO_OVF;

  int checks = 0;
  int errors = 0;

  // Simple transmitter model: busy for busyLen cycles after each start pulse.
  logic modelEn = 1'b0;
  logic forceBusy = 1'b0;
  int   busyLen = 3;
  int   busyCnt = 0;

  always #5 iCLK = ~iCLK;

  always @(posedge iCLK) begin
    if (modelEn && oTX_START) busyCnt <= busyLen;
    else if (busyCnt > 0)     busyCnt <= busyCnt - 1;
  end

  assign iTX_BUSY = modelEn ? (busyCnt != 0) : forceBusy;

  rs232_tx_arbiter #(.N_REQ(4), .START_TO(4)) dut (
    .iCLK      (iCLK),
    .iRST_N    (iRST_N),
    .iREQ      (iREQ),
    .iREQ_DATA (iREQ_DATA),
    .oACK      (oACK),
    .oTX_DATA  (oTX_DATA),
    .oTX_START (oTX_START),
    .iTX_BUSY  (iTX_BUSY),
    .iRX_READY (iRX_READY),
    .iRX_DATA  (iRX_DATA),
    .oGRANT    (oGRANT),
    .oBUSY     (oBUSY),
    .oECHO_OVF (oECHO_OVF)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge iCLK);
    #1;
  endtask

  task automatic resetDut();
    iRST_N    = 1'b0;
    iREQ      = '0;
    iRX_READY = 1'b0;
    repeat (2) @(posedge iCLK);
    #1;
    iRST_N = 1'b1;
  endtask

  task automatic waitStart(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (!oTX_START && n < 200);
    if (!oTX_START) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no start pulse expected start within 200 cycles", tag);
    end
  endtask

  int starts;

  initial begin
    // Reset state, with transmitter held busy: nothing may be granted.
    forceBusy = 1'b1;
    iREQ_DATA = 32'h0000_0000;
    repeat (2) @(posedge iCLK);
    #1;
    check("rst_start", oTX_START, 0);
    check("rst_ack",   oACK, 0);
    check("rst_data",  oTX_DATA, 0);
    check("rst_grant", oGRANT, 0);
    check("rst_busy",  oBUSY, 0);
    check("rst_ovf",   oECHO_OVF, 0);
    iRST_N = 1'b1;
    iREQ   = 4'b0001;
    repeat (3) step();
    check("busy_idle_nostart", oTX_START, 0);
    check("busy_idle_state",   oBUSY, 0);

    // 1. Single requester
    resetDut();
    forceBusy = 1'b0;
    modelEn   = 1'b1;
    busyLen   = 3;
    iREQ_DATA = 32'h0000_A500;
    iREQ_DATA[23:16] = 8'hA5;
    iREQ      = 4'b0100;
    step();
    check("single_start", oTX_START, 1);
    check("single_data",  oTX_DATA, 8'hA5);
    check("single_ack",   oACK, 4'b0100);
    check("single_grant", oGRANT, 2);
    check("single_busy",  oBUSY, 1);
    iREQ = '0;
    step();
    check("single_start_pulse", oTX_START, 0);
    check("single_ack_pulse",   oACK, 0);
    check("single_data_hold",   oTX_DATA, 8'hA5);

    // 2. Fairness: all four requesters, transmitter busy 20 cycles
    resetDut();
    busyLen   = 20;
    iREQ_DATA = 32'h1312_1110;
    iREQ      = 4'hF;
    for (int k = 0; k < 5; k++) begin
      waitStart($sformatf("fair_wait%0d", k));
      check($sformatf("fair_grant%0d", k), oGRANT, k % 4);
      check($sformatf("fair_ack%0d", k),   oACK, 4'b0001 << (k % 4));
      check($sformatf("fair_data%0d", k),  oTX_DATA, 8'h10 + (k % 4));
    end
    iREQ = '0;

    // 3. Timeout: busy stuck low after the start
    resetDut();
    modelEn   = 1'b0;
    forceBusy = 1'b0;
    iREQ_DATA = 32'h8800_7700;
    iREQ      = 4'b0010;
    step();
    check("to_start", oTX_START, 1);
    check("to_grant", oGRANT, 1);
    check("to_data",  oTX_DATA, 8'h77);
    iREQ = 4'b1000;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("to_nostart%0d", i), oTX_START, 0);
      if (i == 5) check("to_waitlo_busy", oBUSY, 1);
      if (i == 6) check("to_idle_busy", oBUSY, 0);
    end
    step();
    check("to_next_start", oTX_START, 1);
    check("to_next_grant", oGRANT, 3);
    check("to_next_data",  oTX_DATA, 8'h88);
    iREQ = '0;

    // 4. Reset during WAIT_LO with transmitter busy
    resetDut();
    iREQ_DATA = 32'h0000_2211;
    iREQ      = 4'b0110;
    step();
    check("rm_grant", oGRANT, 1);
    forceBusy = 1'b1;
    step();
    step();
    check("rm_waitlo_busy", oBUSY, 1);
    iREQ   = 4'b0011;
    iRST_N = 1'b0;
    #2;
    check("rm_rst_start", oTX_START, 0);
    check("rm_rst_ack",   oACK, 0);
    check("rm_rst_data",  oTX_DATA, 0);
    check("rm_rst_grant", oGRANT, 0);
    check("rm_rst_busy",  oBUSY, 0);
    step();
    iRST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rm_hold%0d", i), oTX_START, 0);
    end
    forceBusy = 1'b0;
    step();
    check("rm_first_start", oTX_START, 1);
    check("rm_first_grant", oGRANT, 0);
    check("rm_first_ack",   oACK, 4'b0001);
    check("rm_first_data",  oTX_DATA, 8'h11);
    iREQ = '0;

`ifdef RS232_TX_ARBITER_ECHO_EN
    // 5. Echo is served after the pending requester
    resetDut();
    modelEn   = 1'b1;
    busyLen   = 3;
    iREQ_DATA = 32'h0000_0033;
    iREQ      = 4'b0001;
    iRX_DATA  = 8'h5A;
    iRX_READY = 1'b1;
    step();
    iRX_READY = 1'b0;
    check("echo_req_grant", oGRANT, 0);
    check("echo_req_data",  oTX_DATA, 8'h33);
    iREQ = '0;
    waitStart("echo_wait");
    check("echo_grant", oGRANT, 4);
    check("echo_data",  oTX_DATA, 8'h5A);
    check("echo_ack",   oACK, 0);
    check("echo_ovf",   oECHO_OVF, 0);

    // 6. Echo overflow while a held request blocks echo service
    resetDut();
    iREQ_DATA = 32'h0000_0044;
    iREQ      = 4'b0001;
    iRX_DATA  = 8'h01;
    iRX_READY = 1'b1;
    step();
    iRX_DATA = 8'h02;
    step();
    iRX_READY = 1'b0;
    check("ovf_set", oECHO_OVF, 1);
    iREQ = '0;
    waitStart("ovf_wait");
    check("ovf_grant", oGRANT, 4);
    check("ovf_data",  oTX_DATA, 8'h01);
    starts = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (oTX_START) starts++;
    end
    check("ovf_no_more_starts", starts, 0);
    check("ovf_sticky", oECHO_OVF, 1);
    resetDut();
    check("ovf_cleared", oECHO_OVF, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_tx_arbiter.md
# rs232_tx_arbiter

Round-robin arbiter sharing the single RS232 byte transmitter between `N_REQ` on-chip requesters, such as the display and axis status reporters. It sits between the requesters and the transmit side of `RS232_Controller`. It selects one pending byte, issues a one-cycle start pulse, and holds the data stable until the transmitter reports completion. Each requester receives a one-cycle acknowledge when its byte is committed.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters. Range 2..8.
- `START_TO`, default 4: number of cycles to wait for `iTX_BUSY` to rise after a start pulse.

Ports:
- `iCLK`  in  1  system clock.
- `iRST_N`  in  1  reset, asynchronous, active-low.
- `iREQ`  in  `N_REQ`  per-requester request level.
- `iREQ_DATA`  in  `8*N_REQ`  byte for requester k at bits [8k+7:8k].
- `oACK`  out  `N_REQ`  one-cycle pulse when the requester's byte is committed.
- `oTX_DATA`  out  8  byte to the transmitter.
- `oTX_START`  out  1  one-cycle start pulse to the transmitter.
- `iTX_BUSY`  in  1  transmitter busy.
- `iRX_READY`  in  1  received-byte strobe (used by echo only).
- `iRX_DATA`  in  8  received byte (used by echo only).
- `oGRANT`  out  `$clog2(N_REQ+1)`  index of the current or last grant; the echo source is index `N_REQ`.
- `oBUSY`  out  1  high whenever the state is not IDLE.
- `oECHO_OVF`  out  1  sticky flag: an echo byte was dropped.

## Operation
- FSM states: IDLE → START → WAIT_HI → WAIT_LO → IDLE.
- **IDLE**
  - If `iTX_BUSY`=0 and any request is pending, pick a winner and go to START.
  - Winner selection: round-robin over `iREQ`, searching from `last+1` modulo `N_REQ`.
  - Echo is the lowest-priority source. It is granted only when `iREQ`=0 and it is not part of the rotation.
- **Capture on entering START:** latch the winner's byte into the `oTX_DATA` register. Update `last` only for `iREQ` winners.
- **START** (1 cycle)
  - `oTX_START`=1.
  - `oACK[g]`=1 for an `iREQ` winner; for an echo winner, clear the echo-valid flag instead.
- **WAIT_HI:** go to WAIT_LO when `iTX_BUSY`=1, or after `START_TO` cycles without it (timeout guard).
- **WAIT_LO:** go to IDLE when `iTX_BUSY`=0.
- **Data hold:** `oTX_DATA` stays stable from START until the cycle after WAIT_LO exits.
- **Requester contract:** hold `iREQ` and its data stable until `oACK`. A request dropped before `oACK` is withdrawn without error. A requester may re-raise `iREQ` in the cycle after `oACK`.
- **Simultaneous requests:** exactly one `oACK` bit is set per START; `oACK` is one-hot or zero.
- **`iTX_BUSY`=1 while in IDLE** (external use): wait, grant nothing.
- **Reset mid-operation:** all state returns to IDLE immediately, `last`=`N_REQ-1` (so requester 0 wins first), echo buffer is emptied. A byte already started finishes on the line; the arbiter still waits for `iTX_BUSY`=0 before the next grant.

## Timing
- **Reset values:** `oTX_START`=0, `oACK`=0, `oTX_DATA`=8'h00, `oGRANT`=0, `oBUSY`=0, `oECHO_OVF`=0. All outputs are registered.
- **Latency:** request sampled in IDLE at cycle n → `oTX_START` and `oACK` at n+1.
- **Minimum spacing between start pulses:** 3 cycles plus the transmitter busy time.

## Configuration
- Macro: `RS232_TX_ARBITER_ECHO_EN`.
- **Defined:**
  - A 1-byte echo buffer captures `iRX_DATA` on `iRX_READY`.
  - If `iRX_READY` arrives while the buffer is full, the new byte is dropped and `oECHO_OVF` is set.
  - If capture and service of the echo byte happen in the same cycle, the new byte is kept.
- **Undefined:** `iRX_READY` and `iRX_DATA` are ignored, the echo source never requests, and `oECHO_OVF` is tied to 0.

## Structure
- **Package `rs232_pkg`:**
  - FSM state enum `{IDLE, START, WAIT_HI, WAIT_LO}`.
  - Constant `RS232_BYTE_W`=8.
  - Default `START_TO` value.
- **Sub-module `rr_pick`:** combinational round-robin priority picker, taking `req` and `last` and returning `grant_idx` and `valid`. It is reused by future arbiters.

## Test plan
1. **Single requester:** with `N_REQ`=4, raise `iREQ`=4'b0100 with byte 8'hA5 → one `oTX_START` one cycle later, `oTX_DATA`=8'hA5, `oACK`=4'b0100, `oGRANT`=2.
2. **Fairness:** hold all four requests with bytes 8'h10..8'h13 and model the transmitter busy for 20 cycles → start order 0,1,2,3,0; each `oACK` is one-hot.
3. **Timeout:** keep `iTX_BUSY` stuck at 0 after a start → the FSM leaves WAIT_HI after 4 cycles and returns to IDLE; the next grant proceeds.
4. **Reset mid-operation:** pulse `iRST_N` low during WAIT_LO while `iTX_BUSY`=1 → all outputs return to their reset values; no start pulse occurs until `iTX_BUSY`=0; requester 0 is served first.
5. **Echo priority** (macro defined): send RX byte 8'h5A while `iREQ`=4'b0001 → requester 0 is served first, then echo with `oGRANT`=4 and `oTX_DATA`=8'h5A.
6. **Echo overflow** (macro defined): send RX bytes 8'h01 and 8'h02 while a held request blocks echo service → 8'h01 is transmitted, 8'h02 is dropped, `oECHO_OVF`=1 until reset.
